imm_extend_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the decode stage. It replaces the

---
 rtl/imm_ext_pkg.sv | 43 ++++
 rtl/imm_fmt_classify.sv | 44 ++++
 rtl/imm_extend_pipe.sv | 128 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// imm_ext_pkg : format codes, opcode match values and immediate field positions
// Rev 1.0     : initial release
// ============================================================================
package imm_ext_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_D    = 3'd2,
        FMT_CB   = 3'd3,
        FMT_B    = 3'd4,
        FMT_IW   = 3'd5
    } imm_fmt_e;

    localparam logic [5:0]  c_OP_B    = 6'b000101;
    localparam logic [6:0]  c_OP_CB   = 7'b1011010;
    localparam logic [10:0] c_OP_LDUR = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR = 11'b11111000000;
    localparam logic [8:0]  c_OP_MOVZ = 9'b110100101;
    localparam logic [6:0]  c_OP_ADDI = 7'b1001000;
    localparam logic [6:0]  c_OP_SUBI = 7'b1101000;
    localparam logic [6:0]  c_OP_ORRI = 7'b1011001;

    // Only bits [25:0] carry immediates, so stage 1 keeps just this slice.
    localparam int c_PAYLOAD_W = 26;

    localparam int c_B_MSB   = 25;
    localparam int c_B_LSB   = 0;
    localparam int c_CB_MSB  = 23;
    localparam int c_CB_LSB  = 5;
    localparam int c_D_MSB   = 20;
    localparam int c_D_LSB   = 12;
    localparam int c_IW_MSB  = 20;
    localparam int c_IW_LSB  = 5;
    localparam int c_HW_MSB  = 22;
    localparam int c_HW_LSB  = 21;
    localparam int c_I_MSB   = 21;
    localparam int c_I_LSB   = 10;

endpackage
`default_nettype wire

// File: rtl/imm_fmt_classify.sv
`default_nettype none
// ============================================================================
// imm_fmt_classify : combinational instruction -> imm_fmt_e, first match wins
// Rev 1.0          : initial release
// ============================================================================
module imm_fmt_classify
    import imm_ext_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] i_instr,
    output imm_fmt_e           o_fmt
);

    logic        w_known;
    logic [5:0]  w_op6;
    logic [6:0]  w_op7;
    logic [8:0]  w_op9;
    logic [10:0] w_op11;

    always_comb begin
        w_op6  = i_instr[INSTR_W-1 -: 6];
        w_op7  = i_instr[INSTR_W-1 -: 7];
        w_op9  = i_instr[INSTR_W-1 -: 9];
        w_op11 = i_instr[INSTR_W-1 -: 11];
        // Any X/Z bit makes this compare non-true in 4-state sim; synthesis folds it to 1.
        w_known = ((^i_instr) == (^i_instr));
        o_fmt   = FMT_NONE;
        if (w_known) begin
            if (w_op6 == c_OP_B)
                o_fmt = FMT_B;
            else if (w_op7 == c_OP_CB)
                o_fmt = FMT_CB;
            else if ((w_op11 == c_OP_LDUR) || (w_op11 == c_OP_STUR))
                o_fmt = FMT_D;
            else if (w_op9 == c_OP_MOVZ)
                o_fmt = FMT_IW;
            else if ((w_op7 == c_OP_ADDI) || (w_op7 == c_OP_SUBI) || (w_op7 == c_OP_ORRI))
                o_fmt = FMT_I;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// imm_extend_pipe : 2-stage valid/ready immediate generator (classify, extend)
// Option          : IMM_EXT_BRANCH_SCALE_EN scales B/CB offsets to bytes (<<2)
// Rev 1.0         : initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OUT_W   = 64,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   ext_imm,
    output logic [2:0]         imm_fmt,
    output logic [CNT_W-1:0]   unk_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    imm_fmt_e                 w_fmt_cls;
    logic                     w_advance;
    logic [OUT_W-1:0]         w_ext_imm;
    logic [OUT_W-1:0]         w_iw_base;

    logic                     r_s1_valid_q,   w_s1_valid_d;
    logic [c_PAYLOAD_W-1:0]   r_s1_payload_q, w_s1_payload_d;
    imm_fmt_e                 r_s1_fmt_q,     w_s1_fmt_d;
    logic                     r_out_valid_q,  w_out_valid_d;
    logic [OUT_W-1:0]         r_ext_imm_q,    w_ext_imm_d;
    imm_fmt_e                 r_imm_fmt_q,    w_imm_fmt_d;
    logic [CNT_W-1:0]         r_unk_count_q,  w_unk_count_d;

    imm_fmt_classify #(
        .INSTR_W (INSTR_W)
    ) u_classify (
        .i_instr (instruction),
        .o_fmt   (w_fmt_cls)
    );

    // Extension works from the registered payload and format of stage 1.
    always_comb begin
        w_iw_base = {{(OUT_W-16){1'b0}}, r_s1_payload_q[c_IW_MSB:c_IW_LSB]};
        w_ext_imm = '0;
        case (r_s1_fmt_q)
            FMT_B:  w_ext_imm = {{(OUT_W-(c_B_MSB-c_B_LSB+1)){r_s1_payload_q[c_B_MSB]}},
                                 r_s1_payload_q[c_B_MSB:c_B_LSB]};
            FMT_CB: w_ext_imm = {{(OUT_W-(c_CB_MSB-c_CB_LSB+1)){r_s1_payload_q[c_CB_MSB]}},
                                 r_s1_payload_q[c_CB_MSB:c_CB_LSB]};
            FMT_D:  w_ext_imm = {{(OUT_W-(c_D_MSB-c_D_LSB+1)){r_s1_payload_q[c_D_MSB]}},
                                 r_s1_payload_q[c_D_MSB:c_D_LSB]};
            FMT_IW: w_ext_imm = w_iw_base << {r_s1_payload_q[c_HW_MSB:c_HW_LSB], 4'b0000};
            FMT_I:  w_ext_imm = {{(OUT_W-(c_I_MSB-c_I_LSB+1)){1'b0}},
                                 r_s1_payload_q[c_I_MSB:c_I_LSB]};
            default: w_ext_imm = '0;
        endcase
`ifdef IMM_EXT_BRANCH_SCALE_EN
        if ((r_s1_fmt_q == FMT_B) || (r_s1_fmt_q == FMT_CB))
            w_ext_imm = w_ext_imm << 2;
`else
        w_ext_imm = w_ext_imm;
`endif
    end

    always_comb begin
        w_advance      = !r_out_valid_q || out_ready;

        w_s1_valid_d   = r_s1_valid_q;
        w_s1_payload_d = r_s1_payload_q;
        w_s1_fmt_d     = r_s1_fmt_q;
        w_out_valid_d  = r_out_valid_q;
        w_ext_imm_d    = r_ext_imm_q;
        w_imm_fmt_d    = r_imm_fmt_q;
        w_unk_count_d  = r_unk_count_q;

        if (w_advance) begin
            w_s1_valid_d = in_valid;
            if (in_valid) begin
                w_s1_payload_d = instruction[c_PAYLOAD_W-1:0];
                w_s1_fmt_d     = w_fmt_cls;
            end
            w_out_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_ext_imm_d = w_ext_imm;
                w_imm_fmt_d = r_s1_fmt_q;
            end
        end

        if (r_out_valid_q && out_ready && (r_imm_fmt_q == FMT_NONE) &&
            (r_unk_count_q != c_CNT_MAX))
            w_unk_count_d = r_unk_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q   <= 1'b0;
            r_s1_payload_q <= '0;
            r_s1_fmt_q     <= FMT_NONE;
            r_out_valid_q  <= 1'b0;
            r_ext_imm_q    <= '0;
            r_imm_fmt_q    <= FMT_NONE;
            r_unk_count_q  <= '0;
        end else begin
            r_s1_valid_q   <= w_s1_valid_d;
            r_s1_payload_q <= w_s1_payload_d;
            r_s1_fmt_q     <= w_s1_fmt_d;
            r_out_valid_q  <= w_out_valid_d;
            r_ext_imm_q    <= w_ext_imm_d;
            r_imm_fmt_q    <= w_imm_fmt_d;
            r_unk_count_q  <= w_unk_count_d;
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_out_valid_q;
    assign ext_imm   = r_ext_imm_q;
    assign imm_fmt   = r_imm_fmt_q;
    assign unk_count = r_unk_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// tb_imm_extend_pipe : directed self-checking bench for imm_extend_pipe
// Rev 1.0            : initial release
// ============================================================================
module tb_imm_extend_pipe;

    localparam logic [2:0] c_FMT_NONE = 3'd0;
    localparam logic [2:0] c_FMT_I    = 3'd1;
    localparam logic [2:0] c_FMT_D    = 3'd2;
    localparam logic [2:0] c_FMT_CB   = 3'd3;
    localparam logic [2:0] c_FMT_B    = 3'd4;
    localparam logic [2:0] c_FMT_IW   = 3'd5;

`ifdef IMM_EXT_BRANCH_SCALE_EN
    localparam logic [63:0] c_EXP_CBZ = 64'hFFFF_FFFF_FFFF_FFEC;
    localparam logic [63:0] c_EXP_B   = 64'd256;
`else
    localparam logic [63:0] c_EXP_CBZ = 64'hFFFF_FFFF_FFFF_FFFB;
    localparam logic [63:0] c_EXP_B   = 64'd64;
`endif

    localparam logic [31:0] c_LDUR = 32'hF84402C9;
    localparam logic [31:0] c_CBZ  = 32'hB4FFFF6B;
    localparam logic [31:0] c_BR   = 32'h14000040;
    localparam logic [31:0] c_MOVZ = 32'hD2A24689;
    localparam logic [31:0] c_ADDI = 32'h913FFC41;
    localparam logic [31:0] c_ADD  = 32'h8B09026A;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ext_imm;
    logic [2:0]  imm_fmt;
    logic [15:0] unk_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(
        .INSTR_W (32),
        .OUT_W   (64),
        .CNT_W   (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ext_imm     (ext_imm),
        .imm_fmt     (imm_fmt),
        .unk_count   (unk_count)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instruction = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (ext_imm !== 64'd0) begin errors++; $display("FAIL reset_ext_imm: got %h want 0", ext_imm); end
        checks++; if (imm_fmt !== c_FMT_NONE) begin errors++; $display("FAIL reset_imm_fmt: got %0d want 0", imm_fmt); end
        checks++; if (unk_count !== 16'd0) begin errors++; $display("FAIL reset_unk_count: got %0d want 0", unk_count); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_formats();
        logic [31:0] t_ins [5];
        logic [63:0] t_imm [5];
        logic [2:0]  t_fmt [5];
        t_ins = '{c_LDUR, c_CBZ, c_BR, c_MOVZ, c_ADDI};
        t_imm = '{64'd64, c_EXP_CBZ, c_EXP_B, 64'h0000_0000_1234_0000, 64'd4095};
        t_fmt = '{c_FMT_D, c_FMT_CB, c_FMT_B, c_FMT_IW, c_FMT_I};
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; instruction = t_ins[k];
            @(negedge clk);
            in_valid = 1'b0; instruction = '0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt%0d_latency1: out_valid got %b want 0", k, out_valid); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid: got %b want 1", k, out_valid); end
            checks++; if (ext_imm !== t_imm[k]) begin errors++; $display("FAIL fmt%0d_imm: got %0d want %0d", k, $signed(ext_imm), $signed(t_imm[k])); end
            checks++; if (imm_fmt !== t_fmt[k]) begin errors++; $display("FAIL fmt%0d_code: got %0d want %0d", k, imm_fmt, t_fmt[k]); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt%0d_drain: out_valid got %b want 0", k, out_valid); end
        end
        checks++; if (unk_count !== 16'd0) begin errors++; $display("FAIL fmt_unk_count: got %0d want 0", unk_count); end
    endtask

    task automatic test_unknown();
        logic [31:0] t_ins [2];
        t_ins[0] = c_ADD;
        t_ins[1] = 32'hxxxx_xxxx;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; instruction = t_ins[k];
            @(negedge clk);
            in_valid = 1'b0; instruction = '0;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unk%0d_valid: got %b want 1", k, out_valid); end
            checks++; if (ext_imm !== 64'd0) begin errors++; $display("FAIL unk%0d_imm: got %h want 0", k, ext_imm); end
            checks++; if (imm_fmt !== c_FMT_NONE) begin errors++; $display("FAIL unk%0d_code: got %0d want 0", k, imm_fmt); end
            checks++; if (unk_count !== 16'(k)) begin errors++; $display("FAIL unk%0d_count_before: got %0d want %0d", k, unk_count, k); end
            @(negedge clk);
            checks++; if (unk_count !== 16'(k + 1)) begin errors++; $display("FAIL unk%0d_count_after: got %0d want %0d", k, unk_count, k + 1); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] t_ins [4];
        logic [63:0] t_imm [4];
        logic [2:0]  t_fmt [4];
        t_ins = '{c_BR, c_ADDI, c_LDUR, c_MOVZ};
        t_imm = '{c_EXP_B, 64'd4095, 64'd64, 64'h0000_0000_1234_0000};
        t_fmt = '{c_FMT_B, c_FMT_I, c_FMT_D, c_FMT_IW};
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c >= 2 && c < 6) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid: got %b want 1", c - 2, out_valid); end
                checks++; if (ext_imm !== t_imm[c-2]) begin errors++; $display("FAIL b2b%0d_imm: got %0d want %0d", c - 2, $signed(ext_imm), $signed(t_imm[c-2])); end
                checks++; if (imm_fmt !== t_fmt[c-2]) begin errors++; $display("FAIL b2b%0d_code: got %0d want %0d", c - 2, imm_fmt, t_fmt[c-2]); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: out_valid got %b want 0", c, out_valid); end
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b want 1", c, in_ready); end
            in_valid    = (c < 4);
            instruction = (c < 4) ? t_ins[c] : 32'd0;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] src_ins [4];
        logic [63:0] src_imm [4];
        logic [2:0]  src_fmt [4];
        logic [63:0] exp_imm_q [$];
        logic [2:0]  exp_fmt_q [$];
        logic [63:0] want_imm;
        logic [2:0]  want_fmt;
        logic [63:0] prev_imm;
        logic [2:0]  prev_fmt;
        logic        held;
        logic        want_rdy;
        int          sent;
        int          got;
        int          unk_exp;
        src_ins = '{c_LDUR, c_CBZ, c_ADD, c_MOVZ};
        src_imm = '{64'd64, c_EXP_CBZ, 64'd0, 64'h0000_0000_1234_0000};
        src_fmt = '{c_FMT_D, c_FMT_CB, c_FMT_NONE, c_FMT_IW};
        sent = 0; got = 0; unk_exp = 2; held = 1'b0;
        prev_imm = '0; prev_fmt = '0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            out_ready   = !(c >= 2 && c <= 4);
            in_valid    = (sent < 4);
            instruction = (sent < 4) ? src_ins[sent] : 32'd0;
            #1;
            if (held) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, out_valid); end
                checks++; if (ext_imm !== prev_imm) begin errors++; $display("FAIL bp_hold_imm c%0d: got %h want %h", c, ext_imm, prev_imm); end
                checks++; if (imm_fmt !== prev_fmt) begin errors++; $display("FAIL bp_hold_code c%0d: got %0d want %0d", c, imm_fmt, prev_fmt); end
            end
            want_rdy = out_ready || !out_valid;
            checks++; if (in_ready !== want_rdy) begin errors++; $display("FAIL bp_in_ready c%0d: got %b want %b", c, in_ready, want_rdy); end
            if (in_valid && in_ready) begin
                exp_imm_q.push_back(src_imm[sent]);
                exp_fmt_q.push_back(src_fmt[sent]);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_imm_q.size() == 0) begin
                    errors++; $display("FAIL bp_spurious c%0d: got imm %h want no output", c, ext_imm);
                end else begin
                    want_imm = exp_imm_q.pop_front();
                    want_fmt = exp_fmt_q.pop_front();
                    if (ext_imm !== want_imm || imm_fmt !== want_fmt) begin
                        errors++; $display("FAIL bp_order%0d: got %h/%0d want %h/%0d", got, ext_imm, imm_fmt, want_imm, want_fmt);
                    end
                    if (want_fmt == c_FMT_NONE) unk_exp++;
                end
                got++;
            end
            held     = out_valid && !out_ready;
            prev_imm = ext_imm;
            prev_fmt = imm_fmt;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 4) begin errors++; $display("FAIL bp_received: got %0d want 4", got); end
        checks++; if (unk_count !== 16'(unk_exp)) begin errors++; $display("FAIL bp_unk_count: got %0d want %0d", unk_count, unk_exp); end
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0; in_valid = 1'b1; instruction = c_ADD;
        @(negedge clk);
        instruction = c_LDUR;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_fill: valid/ready got %b/%b want 1/0", out_valid, in_ready); end
        rst = 1'b1; in_valid = 1'b0; instruction = '0;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (unk_count !== 16'd0) begin errors++; $display("FAIL rst_unk_count: got %0d want 0", unk_count); end
        checks++; if (imm_fmt !== c_FMT_NONE || ext_imm !== 64'd0) begin errors++; $display("FAIL rst_outputs: got %h/%0d want 0/0", ext_imm, imm_fmt); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_quiet%0d: out_valid got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instruction = '0;
        test_reset();
        test_formats();
        test_unknown();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
